audio_fifo_i2s_tx: RTL

//  Read-side consumer of the 1024x16 async audio FIFO. Drains interleaved stereo samples (L,R,L,R...)

---
 rtl/audio_pkg.sv | 7 +
 rtl/i2s_clk_gen.sv | 39 +++
 rtl/audio_fifo_i2s_tx.sv | 95 +++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM encoding, I2S channel constants and underrun counter width.
package audio_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_LOAD, S_RUN} state_t;
  localparam logic I2S_LEFT = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;
  localparam int UNDERRUN_W = 16;
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: bclk divider, falling-edge strobe, bit counter and lrck for the I2S transmitter.
module i2s_clk_gen import audio_pkg::*; #(
  parameter int SLOT_BITS = 16,
  parameter int BCLK_DIV = 4,
  localparam int BW = $clog2(SLOT_BITS),
  localparam int DW = $clog2(BCLK_DIV + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_i,
  output logic          bclk_o,
  output logic          lrck_o,
  output logic          fall_o,
  output logic          wrap_o,
  output logic [BW-1:0] bit_nxt_o
);
  logic [DW-1:0] div_q;
  logic [BW-1:0] bit_q;
  logic          bclk_q, lrck_q, tick;
  assign tick      = run_i && div_q == DW'(BCLK_DIV - 1);
  assign fall_o    = tick && bclk_q;
  assign wrap_o    = bit_q == BW'(SLOT_BITS - 1);
  assign bit_nxt_o = wrap_o ? '0 : bit_q + 1'b1;
  assign bclk_o    = bclk_q;
  assign lrck_o    = lrck_q;
  // Stopping the generator parks the bus with bclk low and the next slot left.
  always_ff @(posedge clk)
    if (rst || !run_i) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      bit_q  <= '0;
      lrck_q <= I2S_LEFT;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) bclk_q <= !bclk_q;
      if (fall_o) bit_q <= bit_nxt_o;
      if (fall_o && wrap_o) lrck_q <= !lrck_q;
    end
endmodule

// File: rtl/audio_fifo_i2s_tx.sv
// audio_fifo_i2s_tx: drains interleaved L/R samples from the audio FIFO read port
// and serialises them as an I2S transmitter with underrun counting.
module audio_fifo_i2s_tx import audio_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int LEVEL_WIDTH = 12,
  parameter int SLOT_BITS = 16,
  parameter int BCLK_DIV = 4,
  parameter int START_LEVEL = 4
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   enable,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   i2s_bclk,
  output logic                   i2s_lrck,
  output logic                   i2s_sdata,
  output logic                   underrun,
  output logic [UNDERRUN_W-1:0]  underrun_cnt,
  output logic                   busy
);
  localparam int BW = $clog2(SLOT_BITS);
  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  hold_q;
  logic [SLOT_BITS-1:0]   slot_q, word;
  logic [UNDERRUN_W-1:0]  underrun_cnt_q;
  logic [BW-1:0]          bit_nxt;
  logic hold_v_q, pend_q, start_q, sdata_q, underrun_q;
  logic fall, wrap, slot_start, stop, starve, pref;
  i2s_clk_gen #(.SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV)) u_clk (
    .clk(rd_clk), .rst(rd_rst), .run_i(state_q == S_RUN), .bclk_o(i2s_bclk), .lrck_o(i2s_lrck),
    .fall_o(fall), .wrap_o(wrap), .bit_nxt_o(bit_nxt)
  );
  // start_q stands in for the slot boundary at the very first left slot after LOAD.
  assign slot_start = start_q || (fall && wrap);
  assign stop       = fall && wrap && i2s_lrck == I2S_RIGHT && !enable;
  assign starve     = slot_start && !hold_v_q && !stop;
  assign pref       = fall && bit_nxt == BW'(SLOT_BITS - 1) && !hold_v_q && !pend_q && !fifo_rd_empty;
  assign word       = (hold_v_q ? SLOT_BITS'(hold_q) : '0) << (SLOT_BITS - DATA_WIDTH);
  assign i2s_sdata    = sdata_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign busy         = state_q != S_IDLE;
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      S_IDLE:  if (enable && !fifo_rd_empty && fifo_rd_water_level >= LEVEL_WIDTH'(START_LEVEL)) state_d = S_PRIME;
      S_PRIME: if (!fifo_rd_empty) begin
        fifo_rd_en = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD:  state_d = S_RUN;
      S_RUN: begin
        fifo_rd_en = pref;
        if (stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rd_rst) fifo_rd_en = 1'b0;
  end
  always_ff @(posedge rd_clk)
    if (rd_rst) begin
      state_q        <= S_IDLE;
      underrun_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (starve && underrun_cnt_q != '1) underrun_cnt_q <= underrun_cnt_q + 1'b1;
    end
  // The shift register keeps the old LSB at the top after the last shift, giving the I2S one-bit delay.
  always_ff @(posedge rd_clk)
    if (rd_rst || stop || state_q == S_IDLE) begin
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      pend_q     <= 1'b0;
      start_q    <= 1'b0;
      slot_q     <= '0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      pend_q     <= fifo_rd_en;
      start_q    <= state_q == S_LOAD;
      underrun_q <= starve;
      if (pend_q) begin
        hold_q   <= fifo_rd_data;
        hold_v_q <= 1'b1;
      end else if (slot_start) hold_v_q <= 1'b0;
      if (slot_start || fall) begin
        sdata_q <= slot_q[SLOT_BITS-1];
        slot_q  <= slot_start ? word : slot_q << 1;
      end
    end
endmodule
